frame_beat_feeder: RTL and testbench

- Upstream feeder for the merged-enable holding register bank.
- Accepts a ready/valid beat stream and frames it into fixed-length frames.
- Drives the bank's registered valid/last/data controls.
- Holds data stable when valid=0, so the bank's hold path and shared clock-gate enable never toggle spuriously.

---
 rtl/frame_beat_feeder_pkg.sv | 15 +
 rtl/frame_skid_buf.sv | 59 +++++
 rtl/frame_beat_feeder.sv | 124 ++++++++++++
 tb/tb_frame_beat_feeder.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/frame_beat_feeder_pkg.sv
// Shared types and defaults for the frame beat feeder.
// Imported by the skid buffer and the top level.
package frame_beat_feeder_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DW_DEF      = 9;
    localparam int CW_DEF      = 4;
    localparam int LEN_RST_DEF = 4;
    localparam int FRAME_CNT_W = 8;

endpackage

// File: rtl/frame_skid_buf.sv
// Two-entry FIFO skid buffer for upstream beats.
// Not-full is registered so s_ready never comes combinationally.
module frame_skid_buf
    import frame_beat_feeder_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [DW-1:0] i_din,
    output logic [DW-1:0] o_head,
    output logic [1:0]    o_count,
    output logic          o_not_full
);

    logic [DW-1:0] r_mem [2];
    logic          r_rd;
    logic          r_wr;
    logic [1:0]    r_cnt;
    logic          r_not_full;
    logic [1:0]    w_cnt_nxt;

    always_comb begin
        w_cnt_nxt = r_cnt;
        unique case ({i_push, i_pop})
            2'b10:   w_cnt_nxt = r_cnt + 2'd1;
            2'b01:   w_cnt_nxt = r_cnt - 2'd1;
            default: w_cnt_nxt = r_cnt;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mem[0]   <= '0;
            r_mem[1]   <= '0;
            r_rd       <= 1'b0;
            r_wr       <= 1'b0;
            r_cnt      <= 2'd0;
            r_not_full <= 1'b0;
        end else begin
            if (i_push) begin
                r_mem[r_wr] <= i_din;
                r_wr        <= ~r_wr;
            end
            if (i_pop) begin
                r_rd <= ~r_rd;
            end
            r_cnt      <= w_cnt_nxt;
            r_not_full <= (w_cnt_nxt != 2'd2);
        end
    end

    assign o_head     = r_mem[r_rd];
    assign o_count    = r_cnt;
    assign o_not_full = r_not_full;

endmodule

// File: rtl/frame_beat_feeder.sv
// Frames a ready/valid beat stream into fixed-length frames
// and drives registered valid/last/data into the holding bank.
module frame_beat_feeder
    import frame_beat_feeder_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int CW      = CW_DEF,
    parameter int LEN_RST = LEN_RST_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [DW-1:0]          s_data,
    input  logic [CW-1:0]          cfg_len,
    input  logic                   cfg_load,
    input  logic                   dn_stall,
    output logic                   valid,
    output logic                   last,
    output logic [DW-1:0]          data,
    output logic [FRAME_CNT_W-1:0] frame_cnt,
    output logic                   err_len0
);

    state_t                 r_state;
    logic [CW-1:0]          r_len_reg;
    logic [CW-1:0]          r_len_act;
    logic [CW-1:0]          r_beat_cnt;
    logic                   r_valid;
    logic                   r_last;
    logic [DW-1:0]          r_data;
    logic [FRAME_CNT_W-1:0] r_frame_cnt;
    logic                   r_err_len0;

    logic                   w_ready;
    logic                   w_push;
    logic                   w_issue;
    logic                   w_last;
    logic [DW-1:0]          w_head;
    logic [1:0]             w_count;

    assign w_push  = s_valid & w_ready;
    assign w_issue = (w_count != 2'd0) & ~dn_stall;

    // In IDLE the frame length is not latched yet, so use len_reg.
    always_comb begin
        w_last = 1'b0;
        unique case (r_state)
            IDLE: w_last = (r_len_reg == CW'(1));
            RUN:  w_last = (r_beat_cnt == r_len_act - CW'(1));
            default: w_last = 1'b0;
        endcase
    end

    frame_skid_buf #(
        .DW (DW)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push),
        .i_pop      (w_issue),
        .i_din      (s_data),
        .o_head     (w_head),
        .o_count    (w_count),
        .o_not_full (w_ready)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_len_reg   <= CW'(LEN_RST);
            r_len_act   <= CW'(LEN_RST);
            r_beat_cnt  <= '0;
            r_valid     <= 1'b0;
            r_last      <= 1'b0;
            r_data      <= '0;
            r_frame_cnt <= '0;
            r_err_len0  <= 1'b0;
        end else begin
            if (cfg_load) begin
                if (cfg_len == '0) begin
                    r_len_reg  <= CW'(1);
                    r_err_len0 <= 1'b1;
                end else begin
                    r_len_reg <= cfg_len;
                end
            end
            r_valid <= w_issue;
            r_last  <= w_issue & w_last;
            if (w_issue) begin
                r_data <= w_head;
                if (w_last) begin
                    r_frame_cnt <= r_frame_cnt + 1'b1;
                end
                unique case (r_state)
                    IDLE: begin
                        r_len_act <= r_len_reg;
                        if (!w_last) begin
                            r_state    <= RUN;
                            r_beat_cnt <= CW'(1);
                        end
                    end
                    RUN: begin
                        if (w_last) begin
                            r_state    <= IDLE;
                            r_beat_cnt <= '0;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + CW'(1);
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign s_ready   = w_ready;
    assign valid     = r_valid;
    assign last      = r_last;
    assign data      = r_data;
    assign frame_cnt = r_frame_cnt;
    assign err_len0  = r_err_len0;

endmodule

// File: tb/tb_frame_beat_feeder.sv
// Directed bench for frame_beat_feeder.
// Checks framing, stalls, length reloads and mid-frame reset.
module tb_frame_beat_feeder;

    logic       clk = 1'b0;
    logic       rst;
    logic       s_valid;
    logic       s_ready;
    logic [8:0] s_data;
    logic [3:0] cfg_len;
    logic       cfg_load;
    logic       dn_stall;
    logic       valid;
    logic       last;
    logic [8:0] data;
    logic [7:0] frame_cnt;
    logic       err_len0;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    frame_beat_feeder dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .cfg_len   (cfg_len),
        .cfg_load  (cfg_load),
        .dn_stall  (dn_stall),
        .valid     (valid),
        .last      (last),
        .data      (data),
        .frame_cnt (frame_cnt),
        .err_len0  (err_len0)
    );

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic       sv,
                        input logic [8:0] sd,
                        input logic       st,
                        input logic       ld,
                        input logic [3:0] ln,
                        input logic       ev,
                        input logic       el,
                        input logic [8:0] ed,
                        input string      tag);
        s_valid  = sv;
        s_data   = sd;
        dn_stall = st;
        cfg_load = ld;
        cfg_len  = ln;
        tick();
        cfg_load = 1'b0;
        chk({tag, "_valid"}, 32'(valid), 32'(ev));
        chk({tag, "_last"}, 32'(last), 32'(el));
        chk({tag, "_data"}, 32'(data), 32'(ed));
    endtask

    initial begin
        logic [8:0] ed;
        rst      = 1'b0;
        s_valid  = 1'b0;
        s_data   = '0;
        cfg_len  = '0;
        cfg_load = 1'b0;
        dn_stall = 1'b0;
        repeat (2) tick();
        chk("rst_valid", 32'(valid), 32'(0));
        chk("rst_last", 32'(last), 32'(0));
        chk("rst_data", 32'(data), 32'(0));
        chk("rst_fcnt", 32'(frame_cnt), 32'(0));
        chk("rst_err", 32'(err_len0), 32'(0));
        chk("rst_ready", 32'(s_ready), 32'(0));
        rst = 1'b1;
        tick();
        chk("rel_ready", 32'(s_ready), 32'(1));

        // Default length 4.
        step(1, 9'h011, 0, 0, 0, 0, 0, 9'h000, "t1_0");
        step(1, 9'h022, 0, 0, 0, 1, 0, 9'h011, "t1_1");
        step(1, 9'h033, 0, 0, 0, 1, 0, 9'h022, "t1_2");
        step(1, 9'h044, 0, 0, 0, 1, 0, 9'h033, "t1_3");
        step(0, 9'h000, 0, 0, 0, 1, 1, 9'h044, "t1_4");
        chk("t1_fcnt", 32'(frame_cnt), 32'(1));
        step(0, 9'h000, 0, 0, 0, 0, 0, 9'h044, "t1_5");

        // Length 2, eight beats back-to-back.
        step(0, 9'h000, 0, 1, 4'd2, 0, 0, 9'h044, "t2_ld");
        for (int i = 1; i <= 9; i++) begin
            ed = (i >= 2) ? 9'(i - 1) : 9'h044;
            step(i <= 8, 9'(i), 0, 0, 0, i >= 2,
                 (i >= 2) && ((i - 1) % 2 == 0), ed,
                 $sformatf("t2_%0d", i));
        end
        chk("t2_fcnt", 32'(frame_cnt), 32'(5));

        // Stall for five cycles while pushing.
        step(1, 9'h1A1, 1, 0, 0, 0, 0, 9'h008, "t3_1");
        chk("t3_rdy1", 32'(s_ready), 32'(1));
        step(1, 9'h1A2, 1, 0, 0, 0, 0, 9'h008, "t3_2");
        chk("t3_rdy2", 32'(s_ready), 32'(0));
        for (int i = 3; i <= 5; i++) begin
            step(1, 9'h1A3, 1, 0, 0, 0, 0, 9'h008,
                 $sformatf("t3_%0d", i));
            chk($sformatf("t3_rdy%0d", i), 32'(s_ready), 32'(0));
        end
        step(1, 9'h1A3, 0, 0, 0, 1, 0, 9'h1A1, "t3_6");
        chk("t3_rdy6", 32'(s_ready), 32'(1));
        step(1, 9'h1A3, 0, 0, 0, 1, 1, 9'h1A2, "t3_7");
        step(0, 9'h000, 0, 0, 0, 1, 0, 9'h1A3, "t3_8");
        step(1, 9'h1A4, 0, 0, 0, 0, 0, 9'h1A3, "t3_9");
        step(0, 9'h000, 0, 0, 0, 1, 1, 9'h1A4, "t3_10");
        chk("t3_fcnt", 32'(frame_cnt), 32'(7));

        // Length 3, reload 5 mid-frame.
        step(0, 9'h000, 0, 1, 4'd3, 0, 0, 9'h1A4, "t4_ld");
        for (int i = 1; i <= 9; i++) begin
            ed = (i >= 2) ? 9'(9'h100 + i - 1) : 9'h1A4;
            step(i <= 8, 9'(9'h100 + i), 0, i == 3, 4'd5,
                 i >= 2, (i == 4) || (i == 9), ed,
                 $sformatf("t4_%0d", i));
        end
        chk("t4_fcnt", 32'(frame_cnt), 32'(9));

        // Zero length loads as 1 and flags an error.
        step(0, 9'h000, 0, 1, 4'd0, 0, 0, 9'h108, "t5_ld");
        chk("t5_err", 32'(err_len0), 32'(1));
        for (int i = 1; i <= 4; i++) begin
            ed = (i >= 2) ? 9'(9'h0C0 + i - 1) : 9'h108;
            step(i <= 3, 9'(9'h0C0 + i), 0, 0, 0,
                 i >= 2, i >= 2, ed, $sformatf("t5_%0d", i));
        end
        chk("t5_fcnt", 32'(frame_cnt), 32'(12));
        chk("t5_err2", 32'(err_len0), 32'(1));

        // Reset mid-frame with one beat buffered.
        step(0, 9'h000, 0, 1, 4'd4, 0, 0, 9'h0C3, "t6_ld");
        step(1, 9'h0D1, 0, 0, 0, 0, 0, 9'h0C3, "t6_1");
        step(1, 9'h0D2, 0, 0, 0, 1, 0, 9'h0D1, "t6_2");
        step(1, 9'h0D3, 0, 0, 0, 1, 0, 9'h0D2, "t6_3");
        step(0, 9'h000, 1, 0, 0, 0, 0, 9'h0D2, "t6_4");
        chk("t6_rdy", 32'(s_ready), 32'(1));
        rst = 1'b0;
        #1;
        chk("t6_r_valid", 32'(valid), 32'(0));
        chk("t6_r_data", 32'(data), 32'(0));
        chk("t6_r_fcnt", 32'(frame_cnt), 32'(0));
        chk("t6_r_err", 32'(err_len0), 32'(0));
        chk("t6_r_ready", 32'(s_ready), 32'(0));
        dn_stall = 1'b0;
        tick();
        rst = 1'b1;
        step(0, 9'h000, 0, 0, 0, 0, 0, 9'h000, "t6_5");
        chk("t6_rdy2", 32'(s_ready), 32'(1));
        step(0, 9'h000, 0, 0, 0, 0, 0, 9'h000, "t6_6");
        for (int i = 1; i <= 5; i++) begin
            ed = (i >= 2) ? 9'(9'h0E0 + i - 1) : 9'h000;
            step(i <= 4, 9'(9'h0E0 + i), 0, 0, 0,
                 i >= 2, i == 5, ed, $sformatf("t6_e%0d", i));
        end
        chk("t6_fcnt", 32'(frame_cnt), 32'(1));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
